rtc_bus_scheduler: RTL
======================

Name: rtc_bus_scheduler

Overview:
- Shares the single RTC transaction engine (the write/read bus FSM that drives a_d, cs, rd, wr) between three requesters: init sequencer, write (escritura) sequencer and read (lectura) sequencer.
- Forces an RTC init after reset.
- Generates periodic read requests.
- Grants the engine one transaction at a time with fixed priority and a timeout guard.

Parameters:
- PER_LEC, 10_000_000, clock cycles between automatic read requests (minimum 4)
- TIMEOUT, 1023, maximum cycles in RUN without eng_done before abort
- CW, 24, width of the periodic counter; must satisfy 2^CW > PER_LEC

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- req_ini  in  1  one-cycle pulse, request re-initialisation of RTC
- req_esc  in  1  level, write requester wants the bus; held until fin_esc
- req_lec  in  1  one-cycle pulse, on-demand read request
- eng_done  in  1  one-cycle pulse from the engine at end of its sequence
- eng_do_it  out  1  engine start/hold, high only in RUN
- eng_w_r  out  1  engine direction, 1=write (init or esc), 0=read
- gnt_ini, gnt_esc, gnt_lec  out  1 each  one-hot grant, high in GRANT and RUN
- fin_ini, fin_esc, fin_lec  out  1 each  one-cycle completion pulse in RELEASE
- ini_ok  out  1  RTC initialised; blocks esc/lec while 0
- err_timeout  out  1  sticky abort flag

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; all grants, fins, eng_do_it, err_timeout and ini_ok = 0; eng_w_r=1; ini_pend=1; lec_pend=0; periodic counter=0.
- Pending bits:
  - ini_pend is set by req_ini.
  - lec_pend is set by req_lec or by a periodic tick.
  - Both are cleared on entry to GRANT for that requester.
  - A set arriving on the same cycle as the clear wins, so the bit stays 1.
- Periodic counter:
  - Counts only while ini_ok=1 and state≠IDLE-with-lec_pend.
  - At PER_LEC-1 it wraps to 0 and produces a tick.
  - A tick while lec_pend=1 is merged (no queueing).
- Arbitration, evaluated in IDLE only: ini_pend > req_esc > lec_pend. esc and lec are eligible only if ini_ok=1.
- States:
  - IDLE: eng_do_it=0. If any request is eligible, latch its ID and go to GRANT.
  - GRANT: 1 cycle. The grant is asserted, eng_w_r is set (ini/esc→1, lec→0) and eng_do_it=0 so muxes settle. Go to RUN.
  - RUN:
    - eng_do_it=1, grant held, eng_w_r stable.
    - The timeout counter starts at 0 and increments each cycle.
    - eng_done → RELEASE and err_timeout cleared.
    - If the counter reaches TIMEOUT → RELEASE and err_timeout=1.
    - If both happen in the same cycle, eng_done wins.
  - RELEASE:
    - 1 cycle. eng_do_it=0, grant dropped, matching fin_* pulsed.
    - If init finished without timeout, ini_ok=1.
    - If init timed out, ini_ok stays 0 and ini_pend is set again, so init retries.
    - Go to IDLE.
- Latency: request eligible in IDLE → grant next cycle → eng_do_it one cycle later. Minimum gap between transactions is 2 cycles (RELEASE, IDLE).
- req_esc dropped during GRANT/RUN: ignored; the transaction completes and fin_esc still pulses.
- req_ini during a transaction: latched and served next, ahead of esc/lec. ini_ok drops to 0 at grant of the re-init.
- A reset mid-transaction aborts immediately. No fin is issued.

Decomposition:
- Package rtc_sched_pkg holds:
  - state encoding IDLE/GRANT/RUN/RELEASE (2 bits)
  - requester IDs ID_INI=0, ID_ESC=1, ID_LEC=2
  - default PER_LEC/TIMEOUT constants
- Sub-module rtc_periodic_timer (CW-bit wrap counter with enable, tick output).

Test Plan:
- Release reset, eng_done returned 5 cycles after eng_do_it rises → gnt_ini 2 cycles after reset deassert, eng_w_r=1, fin_ini pulse, ini_ok=1.
- PER_LEC=20 after init, no other requests → gnt_lec with eng_w_r=0 every 20 cycles ±transaction length, fin_lec each time.
- req_esc and req_lec asserted in the same cycle while IDLE → esc served first (eng_w_r=1), lec served immediately after, two fin pulses in order.
- TIMEOUT=8, eng_done never returned on init → RELEASE after 8 RUN cycles, err_timeout=1, ini_ok=0, init retried; then eng_done given → err_timeout=0, ini_ok=1.
- reset pulsed low during RUN of an esc transaction → all outputs 0 asynchronously, no fin_esc, init re-runs first after release.
- req_lec pulse coinciding with periodic tick and with an ongoing lec grant clear → exactly one additional lec transaction follows.

Source files
------------

// File: rtl/rtc_sched_pkg.sv
// Shared types and defaults for the RTC bus scheduler: FSM states, requester IDs
// and the default periodic / timeout constants.
package rtc_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RUN     = 2'd2,
    RELEASE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ID_INI = 2'd0,
    ID_ESC = 2'd1,
    ID_LEC = 2'd2
  } req_id_t;

  localparam int PER_LEC_DEF = 10_000_000;
  localparam int TIMEOUT_DEF = 1023;
  localparam int CW_DEF      = 24;

  // Grant/fin vectors are ordered {lec, esc, ini}.
  function automatic logic [2:0] id_onehot(req_id_t id);
    return 3'b001 << id;
  endfunction

endpackage

// File: rtl/rtc_periodic_timer.sv
// Free-running wrap counter that emits a one-cycle tick every PERIOD enabled cycles.
module rtc_periodic_timer
  import rtc_sched_pkg::*;
#(
  parameter int PERIOD = PER_LEC_DEF,
  parameter int CW     = CW_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  cnt <= '0;
    else if (en) cnt <= tick ? '0 : cnt + CW'(1);
  end

endmodule

// File: rtl/rtc_bus_scheduler.sv
// Arbitrates the single RTC transaction engine between init, write and read
// sequencers: forced init after reset, periodic reads, fixed priority, timeout guard.
module rtc_bus_scheduler
  import rtc_sched_pkg::*;
#(
  parameter int PER_LEC = PER_LEC_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CW      = CW_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic req_ini,
  input  logic req_esc,
  input  logic req_lec,
  input  logic eng_done,
  output logic eng_do_it,
  output logic eng_w_r,
  output logic gnt_ini,
  output logic gnt_esc,
  output logic gnt_lec,
  output logic fin_ini,
  output logic fin_esc,
  output logic fin_lec,
  output logic ini_ok,
  output logic err_timeout
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t        state;
  req_id_t       cur;
  req_id_t       win;
  logic          ini_pend;
  logic          lec_pend;
  logic          any_req;
  logic          per_en;
  logic          tick;
  logic [TW-1:0] tmo_cnt;

  // The period is frozen while a read is already waiting for the bus.
  assign per_en = ini_ok && !(state == IDLE && lec_pend);

  rtc_periodic_timer #(.PERIOD(PER_LEC), .CW(CW)) u_per (
    .clk   (clk),
    .reset (reset),
    .en    (per_en),
    .tick  (tick)
  );

  always_comb begin
    win = ID_LEC;
    if (ini_pend)               win = ID_INI;
    else if (ini_ok && req_esc) win = ID_ESC;
    any_req = ini_pend || (ini_ok && (req_esc || lec_pend));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cur         <= ID_INI;
      tmo_cnt     <= '0;
      eng_do_it   <= 1'b0;
      eng_w_r     <= 1'b1;
      {gnt_lec, gnt_esc, gnt_ini} <= '0;
      {fin_lec, fin_esc, fin_ini} <= '0;
      ini_ok      <= 1'b0;
      err_timeout <= 1'b0;
      ini_pend    <= 1'b1;
      lec_pend    <= 1'b0;
    end else begin
      {fin_lec, fin_esc, fin_ini} <= '0;
      case (state)
        IDLE: begin
          if (any_req) begin
            cur     <= win;
            state   <= GRANT;
            eng_w_r <= (win != ID_LEC);
            {gnt_lec, gnt_esc, gnt_ini} <= id_onehot(win);
            if (win == ID_INI) begin
              ini_pend <= 1'b0;
              ini_ok   <= 1'b0;
            end
            if (win == ID_LEC) lec_pend <= 1'b0;
          end
        end
        GRANT: begin
          state     <= RUN;
          eng_do_it <= 1'b1;
          tmo_cnt   <= '0;
        end
        RUN: begin
          // eng_done has priority over a timeout landing on the same cycle.
          if (eng_done || tmo_cnt == TW'(TIMEOUT - 1)) begin
            state       <= RELEASE;
            eng_do_it   <= 1'b0;
            err_timeout <= !eng_done;
            {gnt_lec, gnt_esc, gnt_ini} <= '0;
            {fin_lec, fin_esc, fin_ini} <= id_onehot(cur);
            if (cur == ID_INI) begin
              if (eng_done) ini_ok   <= 1'b1;
              else          ini_pend <= 1'b1;
            end
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
      // New requests override a same-cycle clear.
      if (req_ini)          ini_pend <= 1'b1;
      if (req_lec || tick)  lec_pend <= 1'b1;
    end
  end

endmodule
